// File: rtl/rom_loader.sv
// Boot loader: assembles a framed, checksummed byte stream into 16-bit words for the
// instruction memory and keeps the core in reset until a verified image is present.
module rom_loader #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [15:0]       rom_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StDataHi, StDataLo, StChk, StDone, StErr
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [7:0]          chk_q, chk_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic        accept;
  logic        active;
  logic [15:0] len_new;

  assign accept  = rx_valid && ready_q;
  assign active  = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StDataHi) ||
                   (state_q == StDataLo) || (state_q == StChk);
  assign len_new = {len_q[15:8], rx_data};

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    words_d = words_q;
    chk_d   = chk_q;
    len_d   = len_q;
    hi_d    = hi_q;
    cnt_d   = '0;
    if (active && !accept) begin
      cnt_d = cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (accept && rx_data == 8'hA5) begin
          state_d = StLenHi;
          chk_d   = '0;
          words_d = '0;
          err_d   = 1'b0;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          chk_d       = chk_q ^ rx_data;
          state_d     = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = len_new;
          chk_d = chk_q ^ rx_data;
          if (len_new == 16'd0 || 32'(len_new) > DEPTH) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (accept) begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = StDataLo;
        end
      end
      StDataLo: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = words_q[ADDR_W-1:0];
          wdata_d = {hi_q, rx_data};
          words_d = words_q + 1'b1;
          chk_d   = chk_q ^ rx_data;
          state_d = (32'(words_q) + 32'd1 == 32'(len_q)) ? StChk : StDataHi;
        end
      end
      StChk: begin
        if (accept) begin
          if (rx_data == chk_q) begin
            state_d = StDone;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
      StDone, StErr: begin
        // load_err deliberately survives reload until the next header.
        if (reload) begin
          state_d = StIdle;
          hold_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // An accepted byte on the limit cycle takes priority over the timeout.
    if (active && !accept && cnt_q == CntW'(TIMEOUT - 1)) begin
      state_d = StErr;
      err_d   = 1'b1;
      cnt_d   = '0;
    end

    ready_d = (state_d != StDone) && (state_d != StErr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
      chk_q   <= '0;
      len_q   <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      words_q <= words_d;
      chk_q   <= chk_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rx_ready     = ready_q;
  assign rom_we       = we_q;
  assign rom_waddr    = waddr_q;
  assign rom_wdata    = wdata_q;
  assign core_hold    = hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: table of whole frames plus hand-written corner sequences.
module tb_rom_loader;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DEPTH   = 4096;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              reload = 1'b0;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [15:0]       rom_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  rom_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reload(reload), .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [ADDR_W-1:0] wa[$];
  logic [15:0]       wd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Write monitor; words_loaded must already count the word being strobed.
  always @(negedge clk) begin
    if (rst && rom_we) begin
      wa.push_back(rom_waddr);
      wd.push_back(rom_wdata);
      check("words_with_we", 32'(words_loaded), 32'(rom_waddr) + 32'd1);
    end
  end

  task automatic do_reset();
    rst = 1'b0; rx_valid = 1'b0; reload = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    wa.delete(); wd.delete();
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("send_ready", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic send_nominal(input logic [7:0] last);
    logic [63:0] f;
    f = {56'hA5_00_02_12_34_AB_CD, last};
    for (int k = 0; k < 8; k++) send(f[63-8*k -: 8]);
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [95:0] bytes;
    logic        done;
    logic        err;
    logic        hold;
    int          words;
    int          nw;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int first_err;
    logic [7:0] cs;
    vecs[0] = '{"nominal", 8, {64'hA500021234ABCD42, 32'h0}, 1, 0, 0, 2, 2, 16'h1234, 16'hABCD};
    vecs[1] = '{"bad_chk", 8, {64'hA500021234ABCD43, 32'h0}, 0, 1, 1, 2, 2, 16'h1234, 16'hABCD};
    vecs[2] = '{"len_zero", 3, {24'hA50000, 72'h0}, 0, 1, 1, 0, 0, 16'h0, 16'h0};
    vecs[3] = '{"len_big", 3, {24'hA51001, 72'h0}, 0, 1, 1, 0, 0, 16'h0, 16'h0};
    vecs[4] = '{"hunt", 11, {88'h00FF5AA500021234ABCD42, 8'h0}, 1, 0, 0, 2, 2, 16'h1234,
                16'hABCD};
    vecs[5] = '{"one_word", 6, {48'hA50001BEEF50, 48'h0}, 1, 0, 0, 1, 1, 16'hBEEF, 16'h0};

    // Values held during reset, before any clock edge after release.
    rst = 1'b0;
    #12;
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_hold", 32'(core_hold), 32'd1);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_we", 32'(rom_we), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int k = 0; k < vecs[i].n; k++) send(vecs[i].bytes[95-8*k -: 8]);
      @(posedge clk); #1;
      check({vecs[i].name, "_done"}, 32'(load_done), 32'(vecs[i].done));
      check({vecs[i].name, "_err"}, 32'(load_err), 32'(vecs[i].err));
      check({vecs[i].name, "_hold"}, 32'(core_hold), 32'(vecs[i].hold));
      check({vecs[i].name, "_ready"}, 32'(rx_ready), 32'd0);
      check({vecs[i].name, "_words"}, 32'(words_loaded), 32'(vecs[i].words));
      check({vecs[i].name, "_nwrites"}, 32'(wa.size()), 32'(vecs[i].nw));
      if (vecs[i].nw > 0 && wa.size() > 0) begin
        check({vecs[i].name, "_a0"}, 32'(wa[0]), 32'd0);
        check({vecs[i].name, "_d0"}, 32'(wd[0]), 32'(vecs[i].w0));
      end
      if (vecs[i].nw > 1 && wa.size() > 1) begin
        check({vecs[i].name, "_a1"}, 32'(wa[1]), 32'd1);
        check({vecs[i].name, "_d1"}, 32'(wd[1]), 32'(vecs[i].w1));
      end
    end

    // Error, reload, then a good frame clears load_err.
    do_reset();
    send_nominal(8'h43);
    @(posedge clk); #1;
    check("rec_err", 32'(load_err), 32'd1);
    pulse_reload();
    check("rec_ready", 32'(rx_ready), 32'd1);
    check("rec_err_held", 32'(load_err), 32'd1);
    check("rec_hold", 32'(core_hold), 32'd1);
    send_nominal(8'h42);
    @(posedge clk); #1;
    check("rec_err_clr", 32'(load_err), 32'd0);
    check("rec_done", 32'(load_done), 32'd1);
    check("rec_core_hold", 32'(core_hold), 32'd0);
    pulse_reload();
    check("rec_reload_done", 32'(load_done), 32'd0);
    check("rec_reload_hold", 32'(core_hold), 32'd1);

    // Timeout lands exactly TIMEOUT edges after the last accepted byte.
    do_reset();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
    first_err = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (first_err < 0 && load_err) first_err = c;
    end
    check("to_cycle", 32'(first_err), 32'(TIMEOUT));
    check("to_ready", 32'(rx_ready), 32'd0);
    check("to_hold", 32'(core_hold), 32'd1);

    // A byte on the limit edge is consumed instead.
    do_reset();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    rx_data = 8'h34; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("lim_err", 32'(load_err), 32'd0);
    check("lim_word", 32'(rom_wdata), 32'h1234);
    send(8'h27);
    @(posedge clk); #1;
    check("lim_done", 32'(load_done), 32'd1);

    // Asynchronous reset between a high and low data byte.
    do_reset();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'h56);
    #2;
    rst = 1'b0;
    #1;
    check("ar_ready", 32'(rx_ready), 32'd0);
    check("ar_words", 32'(words_loaded), 32'd0);
    check("ar_wdata", 32'(rom_wdata), 32'd0);
    check("ar_waddr", 32'(rom_waddr), 32'd0);
    check("ar_hold", 32'(core_hold), 32'd1);
    check("ar_we", 32'(rom_we), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ar_ready_rel", 32'(rx_ready), 32'd1);
    wa.delete(); wd.delete();
    send_nominal(8'h42);
    @(posedge clk); #1;
    check("ar_reload_done", 32'(load_done), 32'd1);
    check("ar_reload_writes", 32'(wa.size()), 32'd2);

    // Length == DEPTH is legal; the final write lands at DEPTH-1.
    do_reset();
    send(8'hA5); send(8'h10); send(8'h00);
    cs = 8'h10;
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] w;
      w = 16'(i) ^ 16'h5A00;
      send(w[15:8]); send(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    send(cs);
    @(posedge clk); #1;
    check("max_done", 32'(load_done), 32'd1);
    check("max_words", 32'(words_loaded), 32'(DEPTH));
    check("max_nwrites", 32'(wa.size()), 32'(DEPTH));
    if (wa.size() == DEPTH) begin
      check("max_last_addr", 32'(wa[DEPTH-1]), 32'(DEPTH - 1));
      check("max_last_data", 32'(wd[DEPTH-1]), 32'((DEPTH - 1) ^ 32'h5A00));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
